// File: rtl/jump_ctl_if.sv
// Signal bundle between the game controller side (master) and the jump motion controller (slave).
// Carries jump commands, the frame tick, the next-layer occupancy mask and the character pose/status.
interface jump_ctl_if #(
    parameter int NCOLS = 5,
    parameter int COL_W = 3
);
    logic                    frame_tick;
    logic                    layer_generate;
    logic                    jump_left;
    logic                    jump_right;
    logic [NCOLS-1:0]        next_layer_mask;
    logic [COL_W-1:0]        char_col;
    logic signed [7:0]       char_dx;
    logic signed [7:0]       char_dy;
    logic                    character_landed;
    logic                    jump_fail;
    logic                    layer_advance;
    logic                    busy;

    modport master (
        output frame_tick, layer_generate, jump_left, jump_right, next_layer_mask,
        input  char_col, char_dx, char_dy, character_landed, jump_fail, layer_advance, busy
    );

    modport slave (
        input  frame_tick, layer_generate, jump_left, jump_right, next_layer_mask,
        output char_col, char_dx, char_dy, character_landed, jump_fail, layer_advance, busy
    );
endinterface

// File: rtl/jump_ctl.sv
// Character jump/fall sequencer: animates a jump over FLY_FRAMES ticks, checks the landing block,
// then either advances the layer or plays a fall animation ending in DEAD.
module jump_ctl #(
    parameter int NCOLS       = 5,
    parameter int COL_W       = 3,
    parameter int START_COL   = 2,
    parameter int FLY_FRAMES  = 16,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 3,
    parameter int FALL_FRAMES = 20,
    parameter int FALL_STEP   = 6
) (
    input  logic       clk,
    input  logic       rst,
    jump_ctl_if.slave  bus
);
    localparam int HALF  = FLY_FRAMES / 2;
    localparam int MAXF  = (FLY_FRAMES > FALL_FRAMES) ? FLY_FRAMES : FALL_FRAMES;
    localparam int CNT_W = $clog2(MAXF + 1);

    localparam logic [7:0] STEP_Y8    = 8'(STEP_Y);
    localparam logic [7:0] FALL_STEP8 = 8'(FALL_STEP);

    typedef enum logic [1:0] {IDLE, FLY, FALL, DEAD} state_t;

    state_t           state_reg, state_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [COL_W:0]   target_reg, target_next;
    logic [7:0]       dx_reg, dx_next;
    logic [7:0]       dy_reg, dy_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_left_reg, dir_left_next;
    logic             landed_reg, landed_next;
    logic             fail_reg, fail_next;
    logic             adv_reg, adv_next;
    logic             busy_reg, busy_next;

    logic [CNT_W-1:0]       frame_k;
    logic [7:0]             dx_mag;
    logic [2**COL_W-1:0]    mask_ext;
    logic                   target_in_range;
    logic                   target_ok;

    // Pad the mask to a power of two so the target can index it directly.
    genvar gi;
    generate
        for (gi = 0; gi < 2**COL_W; gi++) begin : g_mask
            if (gi < NCOLS) begin : g_col
                assign mask_ext[gi] = bus.next_layer_mask[gi];
            end else begin : g_pad
                assign mask_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Target is one bit wider than a column so column 0 going left reads as all-ones, never in range.
    assign target_in_range = (target_reg < (COL_W+1)'(NCOLS));
    assign target_ok       = target_in_range && mask_ext[target_reg[COL_W-1:0]];
    assign frame_k         = cnt_reg + CNT_W'(1);
    assign dx_mag          = 8'(STEP_X * int'(frame_k));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            col_reg      <= COL_W'(START_COL);
            target_reg   <= '0;
            dx_reg       <= '0;
            dy_reg       <= '0;
            cnt_reg      <= '0;
            dir_left_reg <= 1'b0;
            landed_reg   <= 1'b0;
            fail_reg     <= 1'b0;
            adv_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            target_reg   <= target_next;
            dx_reg       <= dx_next;
            dy_reg       <= dy_next;
            cnt_reg      <= cnt_next;
            dir_left_reg <= dir_left_next;
            landed_reg   <= landed_next;
            fail_reg     <= fail_next;
            adv_reg      <= adv_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        target_next   = target_reg;
        dx_next       = dx_reg;
        dy_next       = dy_reg;
        cnt_next      = cnt_reg;
        dir_left_next = dir_left_reg;
        landed_next   = 1'b0;
        fail_next     = fail_reg;
        adv_next      = 1'b0;
        busy_next     = busy_reg;

        if (bus.layer_generate) begin
            state_next    = IDLE;
            col_next      = COL_W'(START_COL);
            target_next   = '0;
            dx_next       = '0;
            dy_next       = '0;
            cnt_next      = '0;
            dir_left_next = 1'b0;
            fail_next     = 1'b0;
            busy_next     = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.jump_left ^ bus.jump_right) begin
                        dir_left_next = bus.jump_left;
                        target_next   = bus.jump_left ? ({1'b0, col_reg} - (COL_W+1)'(1))
                                                      : ({1'b0, col_reg} + (COL_W+1)'(1));
                        cnt_next      = '0;
                        busy_next     = 1'b1;
                        state_next    = FLY;
                    end
                end
                FLY: begin
                    if (bus.frame_tick) begin
                        cnt_next = frame_k;
                        dx_next  = dir_left_reg ? -dx_mag : dx_mag;
                        dy_next  = (frame_k <= CNT_W'(HALF)) ? (dy_reg + STEP_Y8) : (dy_reg - STEP_Y8);
                        if (frame_k == CNT_W'(FLY_FRAMES)) begin
                            dx_next     = '0;
                            dy_next     = '0;
                            cnt_next    = '0;
                            landed_next = 1'b1;
                            if (target_in_range) begin
                                col_next = target_reg[COL_W-1:0];
                            end
                            if (target_ok) begin
                                adv_next   = 1'b1;
                                busy_next  = 1'b0;
                                state_next = IDLE;
                            end else begin
                                fail_next  = 1'b1;
                                state_next = FALL;
                            end
                        end
                    end
                end
                FALL: begin
                    if (bus.frame_tick) begin
                        cnt_next = frame_k;
                        dy_next  = dy_reg - FALL_STEP8;
                        if (frame_k == CNT_W'(FALL_FRAMES)) begin
                            cnt_next    = '0;
                            landed_next = 1'b1;
                            busy_next   = 1'b0;
                            state_next  = DEAD;
                        end
                    end
                end
                DEAD: begin
                    state_next = DEAD;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.char_col         = col_reg;
    assign bus.char_dx          = dx_reg;
    assign bus.char_dy          = dy_reg;
    assign bus.character_landed = landed_reg;
    assign bus.jump_fail        = fail_reg;
    assign bus.layer_advance    = adv_reg;
    assign bus.busy             = busy_reg;
endmodule

// File: tb/tb_jump_ctl.sv
// Directed bench for jump_ctl: jumps, landings, falls, new-game clear and mid-flight reset,
// each compared against hand-computed pose and flag values.
module tb_jump_ctl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    jump_ctl_if #(.NCOLS(5), .COL_W(3)) bus ();

    jump_ctl #(
        .NCOLS(5), .COL_W(3), .START_COL(2), .FLY_FRAMES(16), .STEP_X(4),
        .STEP_Y(3), .FALL_FRAMES(20), .FALL_STEP(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic jump(input logic l, input logic r);
        bus.jump_left  = l;
        bus.jump_right = r;
        step();
        bus.jump_left  = 1'b0;
        bus.jump_right = 1'b0;
    endtask

    // Full successful or failed fly with landing checks; exp_col is the column after landing.
    task automatic fly(input string tag, input logic l, input logic [4:0] mask,
                       input int exp_col, input int exp_adv, input int exp_fail);
        bus.next_layer_mask = mask;
        jump(l, !l);
        ticks(16);
        $display("jump %s dir=%s mask=%b -> col=%0d adv=%0d fail=%0d", tag, l ? "L" : "R",
                 mask, bus.char_col, bus.layer_advance, bus.jump_fail);
        check({tag, "_landed"}, int'(bus.character_landed), 1);
        check({tag, "_col"}, int'(bus.char_col), exp_col);
        check({tag, "_adv"}, int'(bus.layer_advance), exp_adv);
        check({tag, "_fail"}, int'(bus.jump_fail), exp_fail);
        step();
        check({tag, "_landed_pulse"}, int'(bus.character_landed), 0);
    endtask

    initial begin
        bus.frame_tick      = 1'b0;
        bus.layer_generate  = 1'b0;
        bus.jump_left       = 1'b0;
        bus.jump_right      = 1'b0;
        bus.next_layer_mask = 5'b00000;

        repeat (3) step();
        rst = 1'b1;
        repeat (50) step();
        check("rst_col", int'(bus.char_col), 2);
        check("rst_dx", int'(bus.char_dx), 0);
        check("rst_dy", int'(bus.char_dy), 0);
        check("rst_landed", int'(bus.character_landed), 0);
        check("rst_fail", int'(bus.jump_fail), 0);
        check("rst_adv", int'(bus.layer_advance), 0);
        check("rst_busy", int'(bus.busy), 0);

        // Right jump from column 2 onto block in column 3.
        bus.next_layer_mask = 5'b01000;
        jump(1'b0, 1'b1);
        check("r1_busy", int'(bus.busy), 1);
        ticks(8);
        check("r1_dx8", int'(bus.char_dx), 32);
        check("r1_dy8", int'(bus.char_dy), 24);
        ticks(7);
        check("r1_dx15", int'(bus.char_dx), 60);
        check("r1_dy15", int'(bus.char_dy), 3);
        check("r1_landed15", int'(bus.character_landed), 0);
        ticks(1);
        $display("jump r1 dir=R mask=01000 -> col=%0d adv=%0d", bus.char_col, bus.layer_advance);
        check("r1_landed", int'(bus.character_landed), 1);
        check("r1_adv", int'(bus.layer_advance), 1);
        check("r1_col", int'(bus.char_col), 3);
        check("r1_dx", int'(bus.char_dx), 0);
        check("r1_dy", int'(bus.char_dy), 0);
        check("r1_fail", int'(bus.jump_fail), 0);
        check("r1_busy_land", int'(bus.busy), 0);
        step();
        check("r1_landed_pulse", int'(bus.character_landed), 0);
        check("r1_adv_pulse", int'(bus.layer_advance), 0);

        fly("l1", 1'b1, 5'b00100, 2, 1, 0);

        // Left jump from 2 onto empty layer: fail, then fall to DEAD.
        bus.next_layer_mask = 5'b00000;
        jump(1'b1, 1'b0);
        ticks(4);
        check("f_dx4", int'(bus.char_dx), -16);
        ticks(12);
        $display("jump f dir=L mask=00000 -> col=%0d fail=%0d", bus.char_col, bus.jump_fail);
        check("f_landed", int'(bus.character_landed), 1);
        check("f_fail", int'(bus.jump_fail), 1);
        check("f_col", int'(bus.char_col), 1);
        check("f_adv", int'(bus.layer_advance), 0);
        check("f_busy", int'(bus.busy), 1);
        step();
        ticks(19);
        check("fall_dy19", int'(bus.char_dy), -114);
        check("fall_busy19", int'(bus.busy), 1);
        check("fall_landed19", int'(bus.character_landed), 0);
        ticks(1);
        check("fall_dy20", int'(bus.char_dy), -120);
        check("fall_landed", int'(bus.character_landed), 1);
        check("fall_busy", int'(bus.busy), 0);
        step();
        jump(1'b0, 1'b1);
        ticks(20);
        check("dead_col", int'(bus.char_col), 1);
        check("dead_dy", int'(bus.char_dy), -120);
        check("dead_fail", int'(bus.jump_fail), 1);
        check("dead_busy", int'(bus.busy), 0);
        check("dead_landed", int'(bus.character_landed), 0);

        // New game from DEAD.
        bus.layer_generate = 1'b1;
        step();
        step();
        bus.layer_generate = 1'b0;
        $display("layer_generate -> col=%0d fail=%0d", bus.char_col, bus.jump_fail);
        check("lg_col", int'(bus.char_col), 2);
        check("lg_fail", int'(bus.jump_fail), 0);
        check("lg_dy", int'(bus.char_dy), 0);
        fly("r2", 1'b0, 5'b01000, 3, 1, 0);

        // Walk to column 0, then jump left off the edge.
        fly("l2", 1'b1, 5'b11111, 2, 1, 0);
        fly("l3", 1'b1, 5'b11111, 1, 1, 0);
        fly("l4", 1'b1, 5'b11111, 0, 1, 0);
        fly("edge", 1'b1, 5'b11111, 0, 0, 1);
        bus.layer_generate = 1'b1;
        step();
        bus.layer_generate = 1'b0;

        // Both commands at once are ignored.
        jump(1'b1, 1'b1);
        check("both_busy", int'(bus.busy), 0);
        ticks(3);
        check("both_col", int'(bus.char_col), 2);
        check("both_dx", int'(bus.char_dx), 0);

        // Launch with a coincident tick (not counted) and a stray command mid-flight.
        bus.next_layer_mask = 5'b01000;
        bus.frame_tick = 1'b1;
        jump(1'b0, 1'b1);
        bus.frame_tick = 1'b0;
        check("co_busy", int'(bus.busy), 1);
        check("co_dx", int'(bus.char_dx), 0);
        ticks(3);
        check("co_dx3", int'(bus.char_dx), 12);
        jump(1'b0, 1'b1);
        jump(1'b1, 1'b0);
        ticks(12);
        check("co_landed15", int'(bus.character_landed), 0);
        check("co_busy15", int'(bus.busy), 1);
        ticks(1);
        $display("jump co dir=R mask=01000 -> col=%0d adv=%0d", bus.char_col, bus.layer_advance);
        check("co_landed", int'(bus.character_landed), 1);
        check("co_col", int'(bus.char_col), 3);
        check("co_adv", int'(bus.layer_advance), 1);
        step();

        // Asynchronous reset at tick 5 of a flight.
        bus.next_layer_mask = 5'b11111;
        jump(1'b0, 1'b1);
        ticks(5);
        check("ar_dx5", int'(bus.char_dx), 20);
        check("ar_dy5", int'(bus.char_dy), 15);
        rst = 1'b0;
        #1;
        $display("async reset mid-fly -> col=%0d busy=%0d", bus.char_col, bus.busy);
        check("ar_col", int'(bus.char_col), 2);
        check("ar_dx", int'(bus.char_dx), 0);
        check("ar_dy", int'(bus.char_dy), 0);
        check("ar_busy", int'(bus.busy), 0);
        check("ar_landed", int'(bus.character_landed), 0);
        ticks(12);
        check("ar_hold_landed", int'(bus.character_landed), 0);
        rst = 1'b1;
        ticks(16);
        step();
        check("ar_after_busy", int'(bus.busy), 0);
        check("ar_after_landed", int'(bus.character_landed), 0);
        check("ar_after_col", int'(bus.char_col), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
